// File: rtl/multiply_signed_ctrl.sv
// Signed/unsigned sequencing stage around the 32-bit shift-add multiply core:
// converts operands to magnitudes, runs the core, and re-applies the result sign.
module multiply_signed_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 valid,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic                 core_reset,
    output logic [WIDTH-1:0]     core_a,
    output logic [WIDTH-1:0]     core_b,
    input  logic                 core_ready,
    input  logic [2*WIDTH-1:0]   core_product
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Two's complement magnitude; the most negative value maps onto itself,
    // which read as unsigned is exactly the required 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? (~p + ONE_2W) : p;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic                 accept_s;
    logic                 capture_s;
    logic                 fix_s;
    logic                 neg_a_s;
    logic                 neg_b_s;
    logic                 neg_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     core_a_r;
    logic [WIDTH-1:0]     core_b_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 valid_r;
    logic                 core_reset_r;

    // Next-state decode and datapath enables; flush overrides everything.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        fix_s     = 1'b0;
        neg_a_s   = signed_op & a[WIDTH-1];
        neg_b_s   = signed_op & b[WIDTH-1];
        if (flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        accept_s = 1'b1;
                        state_s  = ST_LOAD;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_LOAD: state_s = ST_RUN;
                ST_RUN: begin
                    if (core_ready) begin
                        capture_s = 1'b1;
                        state_s   = ST_FIX;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FIX: begin
                    fix_s   = 1'b1;
                    state_s = ST_DONE;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand, product and result registers; core_a/core_b change only on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_a_r <= {WIDTH{1'b0}};
            core_b_r <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            prod_r   <= {(2*WIDTH){1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                core_a_r <= magnitude(a, neg_a_s);
                core_b_r <= magnitude(b, neg_b_s);
                neg_r    <= neg_a_s ^ neg_b_s;
            end
            if (capture_s) begin
                prod_r <= core_product;
            end
            if (fix_s) begin
                {hi_r, lo_r} <= apply_sign(prod_r, neg_r);
            end
        end
    end

    // Handshake flags registered from the next state so they track the state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r       <= 1'b0;
            valid_r      <= 1'b0;
            core_reset_r <= 1'b1;
        end else begin
            busy_r       <= (state_s == ST_LOAD) || (state_s == ST_RUN) || (state_s == ST_FIX);
            valid_r      <= (state_s == ST_DONE);
            core_reset_r <= (state_s != ST_RUN);
        end
    end

    assign busy       = busy_r;
    assign valid      = valid_r;
    assign hi         = hi_r;
    assign lo         = lo_r;
    assign core_reset = core_reset_r;
    assign core_a     = core_a_r;
    assign core_b     = core_b_r;

endmodule

// File: tb/tb_multiply_signed_ctrl.sv
// Directed bench for multiply_signed_ctrl with a variable-latency core model
// and a per-cycle comparison against an arithmetic reference.
module tb_multiply_signed_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        core_reset;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_ready;
    logic [63:0] core_product;

    int          lat;
    int          run_cnt;
    logic        force_ready;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;
    logic        exp_busy, exp_valid, exp_core_reset;
    logic [63:0] exp_prod;
    logic [31:0] exp_core_a, exp_core_b;

    multiply_signed_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .flush(flush), .busy(busy), .valid(valid),
        .hi(hi), .lo(lo), .core_reset(core_reset), .core_a(core_a),
        .core_b(core_b), .core_ready(core_ready), .core_product(core_product)
    );

    always #5 clk = ~clk;

    // Core model: counts cycles out of reset, product is junk unless ready.
    always @(posedge clk or negedge reset) begin
        if (!reset) run_cnt <= 0;
        else if (core_reset) run_cnt <= 0;
        else run_cnt <= run_cnt + 1;
    end
    assign core_ready   = force_ready | (!core_reset && (run_cnt == lat));
    assign core_product = core_ready ? ({32'd0, core_a} * {32'd0, core_b}) : 64'hDEAD_BEEF_0BAD_F00D;

    function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        if (s) return sx * sy;
        else   return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [31:0] model_mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, expv);
        end
    endtask

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            chk("valid", {63'd0, valid}, {63'd0, exp_valid});
            chk("core_reset", {63'd0, core_reset}, {63'd0, exp_core_reset});
            chk("hilo", {hi, lo}, exp_prod);
            chk("core_a", {32'd0, core_a}, {32'd0, exp_core_a});
            chk("core_b", {32'd0, core_b}, {32'd0, exp_core_b});
        end
    end

    task automatic set_idle_exp();
        exp_busy = 1'b0; exp_valid = 1'b0; exp_core_reset = 1'b1;
    endtask

    task automatic set_reset_exp();
        set_idle_exp();
        exp_prod = 64'd0; exp_core_a = 32'd0; exp_core_b = 32'd0;
    endtask

    // Issue one operation (called at #1 after an edge). Optional ignored start
    // at step ign_k, and abort at step abort_k (kind 0 = flush, 1 = reset).
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts, input int l,
                         input int ign_k, input int abort_k, input int abort_kind);
        logic [63:0] p;
        p   = model_prod(ta, tb_, ts);
        lat = l;
        start = 1'b1; signed_op = ts; a = ta; b = tb_;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; signed_op = $urandom_range(1, 0);
        exp_busy = 1'b1; exp_valid = 1'b0; exp_core_reset = 1'b1;
        exp_core_a = model_mag(ta, ts); exp_core_b = model_mag(tb_, ts);
        for (int k = 1; k <= l + 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k <= l + 1) begin
                exp_busy = 1'b1; exp_valid = 1'b0; exp_core_reset = 1'b0;
            end else if (k == l + 2) begin
                exp_busy = 1'b1; exp_valid = 1'b0; exp_core_reset = 1'b1;
            end else begin
                exp_busy = 1'b0; exp_valid = 1'b1; exp_core_reset = 1'b1; exp_prod = p;
            end
            if (k == ign_k) begin
                start = 1'b1; a = 32'd2; b = 32'd2; signed_op = 1'b0;
            end
            if (k == abort_k && abort_kind == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                set_idle_exp();
                force_ready = 1'b1;
                @(posedge clk); #1;
                force_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                return;
            end
            if (k == abort_k && abort_kind == 1) begin
                #2;
                reset = 1'b0;
                set_reset_exp();
                #1;
                chk("async_reset_busy", {63'd0, busy}, 64'd0);
                chk("async_reset_core_reset", {63'd0, core_reset}, 64'd1);
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = 32'd0; b = 32'd0;
        flush = 1'b0; force_ready = 1'b0; lat = 32;
        set_reset_exp();
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Pin the reference model with hand-computed products.
        chk("model_7xm3", model_prod(32'h7, 32'hFFFF_FFFD, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_m1m1_u", model_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        chk("model_minneg", model_prod(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

        do_op(32'h7, 32'hFFFF_FFFD, 1'b1, 32, -1, -1, 0);
        chk("lit_7xm3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        repeat (2) @(posedge clk);
        #1;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32, -1, -1, 0);
        chk("lit_m1m1_s", {hi, lo}, 64'h0000_0000_0000_0001);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, -1, -1, 0);
        chk("lit_m1m1_u", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 5, -1, -1, 0);
        chk("lit_minneg_core_a", {32'd0, core_a}, 64'h8000_0000);
        chk("lit_minneg", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op(32'h8000_0000, 32'h1, 1'b1, 5, -1, -1, 0);
        chk("lit_minneg_x1", {hi, lo}, 64'hFFFF_FFFF_8000_0000);
        do_op(32'd5, 32'd6, 1'b0, 10, 4, -1, 0);
        chk("lit_ignored_start", {hi, lo}, 64'h1E);
        do_op(32'd2, 32'd2, 1'b0, 1, -1, -1, 0);
        chk("lit_back_to_back", {hi, lo}, 64'h4);
        do_op(32'hFFFF_FFF0, 32'd3, 1'b1, 100, -1, -1, 0);
        chk("lit_lat100", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD0);
        do_op(32'd0, 32'hFFFF_FFFF, 1'b1, 3, -1, -1, 0);
        chk("lit_zero_neg", {hi, lo}, 64'h0);
        do_op(32'd9, 32'd9, 1'b1, 32, -1, 10, 0);
        chk("lit_flush_keeps", {hi, lo}, 64'h0);
        do_op(32'd9, 32'd9, 1'b1, 32, -1, -1, 0);
        chk("lit_after_flush", {hi, lo}, 64'h51);
        do_op(32'd11, 32'd11, 1'b0, 32, -1, 5, 1);
        chk("lit_reset_midrun", {hi, lo}, 64'h0);
        do_op(32'hFFFF_FFFE, 32'd7, 1'b1, 2, -1, -1, 0);
        chk("lit_after_reset", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF2);
        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
